// File: rtl/run_sequencer_if.sv
// Host/core-facing signal bundle of the run sequencer.
// The slave modport is the sequencer; the master modport is the host/core side.
interface run_sequencer_if #(
  parameter int D  = 12,
  parameter int CW = 16
);
  logic          go;
  logic [1:0]    prog_sel;
  logic [D-1:0]  prog_ctr_out;
  logic          cpu_start;
  logic [D-1:0]  start_address;
  logic          busy;
  logic          done;
  logic          timeout;
  logic          err;
  logic [CW-1:0] cycles;

  modport master (
    output go, prog_sel, prog_ctr_out,
    input  cpu_start, start_address, busy, done, timeout, err, cycles
  );

  modport slave (
    input  go, prog_sel, prog_ctr_out,
    output cpu_start, start_address, busy, done, timeout, err, cycles
  );
endinterface

// File: rtl/run_sequencer.sv
// Run controller for the single-cycle core: park at a program start, release, time the run, detect halt.
// Optional macro RUN_SEQ_CHAIN_EN: a go on program 0 runs programs 0, 1 and 2 back to back as one run.
module run_sequencer #(
  parameter int D          = 12,
  parameter int CW         = 16,
  parameter int TMO        = 4000,
  parameter int START_HOLD = 2,
  parameter int START0     = 0,
  parameter int START1     = 200,
  parameter int START2     = 400,
  parameter int HALT0      = 180,
  parameter int HALT1      = 380,
  parameter int HALT2      = 600
) (
  input  logic           clk,
  input  logic           rst_n,
  run_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  localparam int HW = (START_HOLD < 2) ? 1 : $clog2(START_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'(START_HOLD - 1);
  localparam logic [CW:0]   TMO_W     = (CW+1)'(TMO);

  state_t        state_q, state_d;
  logic          arm_q, arm_d;
  logic [1:0]    sel_q, sel_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [D-1:0]  start_address_q, start_address_d;
  logic          cpu_start_q, cpu_start_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          timeout_q, timeout_d;
  logic          err_q, err_d;
  logic [CW-1:0] cycles_q, cycles_d;
`ifdef RUN_SEQ_CHAIN_EN
  logic          chain_q, chain_d;
  logic [1:0]    sel_next;
`endif

  logic [D-1:0]  start_tab [4];
  logic [D-1:0]  halt_tab  [4];
  logic [CW:0]   cnt_inc;
  logic          halt_hit;
  logic          tmo_hit;

  // Entry 3 is the illegal selector; it is never used for addressing.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_tab
      localparam int S = (gi == 0) ? START0 : (gi == 1) ? START1 : (gi == 2) ? START2 : 0;
      localparam int H = (gi == 0) ? HALT0  : (gi == 1) ? HALT1  : (gi == 2) ? HALT2  : 0;
      assign start_tab[gi] = D'(S);
      assign halt_tab[gi]  = D'(H);
    end
  endgenerate

  // One extra bit so the limit compare cannot be defeated by a wrap.
  assign cnt_inc  = {1'b0, cycles_q} + {{CW{1'b0}}, 1'b1};
  assign halt_hit = (bus.prog_ctr_out == halt_tab[sel_q]);
  assign tmo_hit  = (cnt_inc >= TMO_W);
`ifdef RUN_SEQ_CHAIN_EN
  assign sel_next = sel_q + 2'd1;
`endif

  always_comb begin
    state_d         = state_q;
    arm_d           = arm_q;
    sel_d           = sel_q;
    hold_d          = hold_q;
    start_address_d = start_address_q;
    cpu_start_d     = cpu_start_q;
    busy_d          = busy_q;
    done_d          = 1'b0;
    timeout_d       = timeout_q;
    err_d           = err_q;
    cycles_d        = cycles_q;
`ifdef RUN_SEQ_CHAIN_EN
    chain_d         = chain_q;
`endif

    case (state_q)
      IDLE: begin
        cpu_start_d = 1'b1;
        busy_d      = 1'b0;
        // go is captured first; the run is set up from the captured selector one edge later.
        if (arm_q) begin
          arm_d = 1'b0;
          if (sel_q == 2'd3) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            start_address_d = start_tab[sel_q];
            cycles_d        = '0;
            timeout_d       = 1'b0;
            err_d           = 1'b0;
            hold_d          = '0;
            busy_d          = 1'b1;
            state_d         = LOAD;
`ifdef RUN_SEQ_CHAIN_EN
            chain_d         = (sel_q == 2'd0);
`endif
          end
        end else if (bus.go) begin
          arm_d = 1'b1;
          sel_d = bus.prog_sel;
        end
      end

      LOAD: begin
        if (hold_q == HOLD_LAST) begin
          cpu_start_d = 1'b0;
          state_d     = RUN;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end

      RUN: begin
        cycles_d = cnt_inc[CW-1:0];
        if (halt_hit) begin
`ifdef RUN_SEQ_CHAIN_EN
          if (chain_q && (sel_q != 2'd2)) begin
            sel_d           = sel_next;
            start_address_d = start_tab[sel_next];
            hold_d          = '0;
            cpu_start_d     = 1'b1;
            state_d         = LOAD;
          end else begin
            cpu_start_d = 1'b1;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            state_d     = DONE;
          end
`else
          cpu_start_d = 1'b1;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          state_d     = DONE;
`endif
        end else if (tmo_hit) begin
          timeout_d   = 1'b1;
          cpu_start_d = 1'b1;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          state_d     = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      arm_q           <= 1'b0;
      sel_q           <= 2'd0;
      hold_q          <= '0;
      start_address_q <= '0;
      cpu_start_q     <= 1'b1;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      timeout_q       <= 1'b0;
      err_q           <= 1'b0;
      cycles_q        <= '0;
`ifdef RUN_SEQ_CHAIN_EN
      chain_q         <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      arm_q           <= arm_d;
      sel_q           <= sel_d;
      hold_q          <= hold_d;
      start_address_q <= start_address_d;
      cpu_start_q     <= cpu_start_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      timeout_q       <= timeout_d;
      err_q           <= err_d;
      cycles_q        <= cycles_d;
`ifdef RUN_SEQ_CHAIN_EN
      chain_q         <= chain_d;
`endif
    end
  end

  assign bus.cpu_start     = cpu_start_q;
  assign bus.start_address = start_address_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.timeout       = timeout_q;
  assign bus.err           = err_q;
  assign bus.cycles        = cycles_q;

endmodule

// File: tb/tb_run_sequencer.sv
// Scoreboard bench for run_sequencer: expected run results are queued at go, a monitor checks each done.
// TMO is set to 181 so program 0 halts exactly on the limit (halt must win).
module tb_run_sequencer;

  localparam int TB_TMO = 181;
`ifdef RUN_SEQ_CHAIN_EN
  // Program 0 halts on the limit, chains into program 1, which then times out on its first cycle.
  localparam logic [11:0] P0_ADDR = 12'd200;
  localparam logic        P0_TMO  = 1'b1;
  localparam logic [15:0] P0_CYC  = 16'd182;
`else
  localparam logic [11:0] P0_ADDR = 12'd0;
  localparam logic        P0_TMO  = 1'b0;
  localparam logic [15:0] P0_CYC  = 16'd181;
`endif

  typedef struct {
    logic [11:0] addr;
    logic        tmo;
    logic        err;
    logic [15:0] cyc;
    bit          chk_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  logic prev_done = 1'b0;
  exp_t sb[$];

  // PC model modes: 0 count up, 1 frozen, 2 jump to halt after a per-program length, 3 stuck at 600.
  int          mode = 0;
  logic [11:0] pc = 12'd0;
  logic [15:0] rc = 16'd0;

  run_sequencer_if #(.D(12), .CW(16)) ifc ();

  run_sequencer #(.TMO(TB_TMO)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] halt_of(input logic [11:0] s);
    if (s == 12'd0) return 12'd180;
    if (s == 12'd200) return 12'd380;
    return 12'd600;
  endfunction

  function automatic logic [15:0] len_of(input logic [11:0] s);
    if (s == 12'd0) return 16'd5;
    if (s == 12'd200) return 16'd7;
    return 16'd9;
  endfunction

  always @(posedge clk) begin
    if (mode == 3) begin
      pc <= 12'd600;
    end else if (ifc.cpu_start) begin
      pc <= ifc.start_address;
      rc <= 16'd0;
    end else begin
      rc <= rc + 16'd1;
      if (mode == 1)
        pc <= pc;
      else if (mode == 2 && (rc + 16'd2) == len_of(ifc.start_address))
        pc <= halt_of(ifc.start_address);
      else
        pc <= pc + 12'd1;
    end
  end
  assign ifc.prog_ctr_out = pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_run(input logic [11:0] a, input logic t, input logic e,
                            input logic [15:0] c, input bit cc);
    exp_t x;
    x.addr = a; x.tmo = t; x.err = e; x.cyc = c; x.chk_cyc = cc;
    sb.push_back(x);
  endtask

  // Monitor: every done pulse pops one expected result; done must last exactly one cycle.
  always @(negedge clk) begin
    exp_t e;
    if (prev_done) chk("done_width", {31'd0, ifc.done}, 32'd0);
    if (ifc.done) begin
      done_cnt <= done_cnt + 1;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 cycles=%0d, expected no done", ifc.cycles);
      end else begin
        e = sb.pop_front();
        chk("done_addr", {20'd0, ifc.start_address}, {20'd0, e.addr});
        chk("done_timeout", {31'd0, ifc.timeout}, {31'd0, e.tmo});
        chk("done_err", {31'd0, ifc.err}, {31'd0, e.err});
        if (e.chk_cyc) chk("done_cycles", {16'd0, ifc.cycles}, {16'd0, e.cyc});
        chk("done_busy", {31'd0, ifc.busy}, 32'd0);
        chk("done_cpu_start", {31'd0, ifc.cpu_start}, 32'd1);
      end
    end
    prev_done <= ifc.done;
  end

  task automatic issue(input logic [1:0] s);
    @(negedge clk);
    ifc.go = 1'b1;
    ifc.prog_sel = s;
    @(negedge clk);
    ifc.go = 1'b0;
    ifc.prog_sel = 2'($urandom_range(0, 3));
  endtask

  task automatic wait_done(input string name, input int budget);
    int base;
    int n;
    base = done_cnt;
    n = 0;
    while (done_cnt == base && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt == base) begin
      checks++;
      errors++;
      $display("FAIL %s: got no done within %0d cycles, expected done", name, budget);
    end
  endtask

  task automatic check_release_latency(input string name);
    int n;
    n = 0;
    while (ifc.cpu_start && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(name, n, 32'd3);
  endtask

  task automatic check_idle(input string pfx);
    chk({pfx, "_cpu_start"}, {31'd0, ifc.cpu_start}, 32'd1);
    chk({pfx, "_busy"}, {31'd0, ifc.busy}, 32'd0);
    chk({pfx, "_done"}, {31'd0, ifc.done}, 32'd0);
    chk({pfx, "_cycles"}, {16'd0, ifc.cycles}, 32'd0);
    chk({pfx, "_addr"}, {20'd0, ifc.start_address}, 32'd0);
  endtask

  initial begin
    int   n;
    logic bad;
    logic prev_cs;
    logic [11:0] falls[$];

    ifc.go = 1'b0;
    ifc.prog_sel = 2'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state held through 5 idle cycles.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_idle("reset");
    end

    // Program 0, counting PC; halt lands exactly on the TMO limit.
    mode = 0;
    expect_run(P0_ADDR, P0_TMO, 1'b0, P0_CYC, 1'b1);
    issue(2'd0);
    check_release_latency("p0_release_latency");
    wait_done("p0_done", 600);

    // Illegal selector: err set, done on the second edge, no LOAD or RUN.
    expect_run(P0_ADDR, 1'b0, 1'b1, 16'd0, 1'b0);
    issue(2'd3);
    chk("err_done_early", {31'd0, ifc.done}, 32'd0);
    @(negedge clk);
    chk("err_done_latency", {31'd0, ifc.done}, 32'd1);
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (ifc.busy || !ifc.cpu_start) bad = 1'b1;
      @(negedge clk);
    end
    chk("err_stays_parked", {31'd0, bad}, 32'd0);

    // Program 1 with frozen PC: timeout at the limit.
    mode = 1;
    expect_run(12'd200, 1'b1, 1'b0, 16'(TB_TMO), 1'b1);
    issue(2'd1);
    wait_done("p1_timeout_done", 600);

    // Program 2 halting in its first RUN cycle; timeout cleared.
    mode = 3;
    expect_run(12'd400, 1'b0, 1'b0, 16'd1, 1'b1);
    issue(2'd2);
    @(negedge clk);
    chk("p2_timeout_cleared", {31'd0, ifc.timeout}, 32'd0);
    chk("p2_addr", {20'd0, ifc.start_address}, 32'd400);
    wait_done("p2_done", 100);

    // Reset mid-run at cycles=50: reset values, no done.
    mode = 0;
    issue(2'd0);
    n = 0;
    while (ifc.cycles != 16'd50 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("mid_reset_reach_50", {16'd0, ifc.cycles}, 32'd50);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_idle("mid_reset");
    chk("mid_reset_timeout", {31'd0, ifc.timeout}, 32'd0);
    chk("mid_reset_err", {31'd0, ifc.err}, 32'd0);

    // go pulses during LOAD and RUN are ignored.
    expect_run(P0_ADDR, P0_TMO, 1'b0, P0_CYC, 1'b1);
    issue(2'd0);
    ifc.go = 1'b1;
    ifc.prog_sel = 2'd3;
    @(negedge clk);
    ifc.go = 1'b0;
    repeat (10) @(negedge clk);
    ifc.go = 1'b1;
    ifc.prog_sel = 2'd1;
    @(negedge clk);
    ifc.go = 1'b0;
    wait_done("ignore_go_done", 600);
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ifc.busy) bad = 1'b1;
    end
    chk("no_queued_run", {31'd0, bad}, 32'd0);

    // Jump-to-halt PC model: chain of 5, 7, 9 cycles or a single 5-cycle run.
    mode = 2;
`ifdef RUN_SEQ_CHAIN_EN
    expect_run(12'd400, 1'b0, 1'b0, 16'd21, 1'b1);
`else
    expect_run(12'd0, 1'b0, 1'b0, 16'd5, 1'b1);
`endif
    issue(2'd0);
    n = 0;
    prev_cs = 1'b1;
    begin
      int base;
      base = done_cnt;
      while (done_cnt == base && n < 200) begin
        if (prev_cs && !ifc.cpu_start) falls.push_back(ifc.start_address);
        prev_cs = ifc.cpu_start;
        @(negedge clk);
        n++;
      end
      if (done_cnt == base) begin
        checks++;
        errors++;
        $display("FAIL jump_done: got no done within 200 cycles, expected done");
      end
    end
`ifdef RUN_SEQ_CHAIN_EN
    chk("chain_releases", falls.size(), 32'd3);
    if (falls.size() == 3) begin
      chk("chain_addr0", {20'd0, falls[0]}, 32'd0);
      chk("chain_addr1", {20'd0, falls[1]}, 32'd200);
      chk("chain_addr2", {20'd0, falls[2]}, 32'd400);
    end
`else
    chk("single_releases", falls.size(), 32'd1);
    if (falls.size() == 1) chk("single_addr0", {20'd0, falls[0]}, 32'd0);
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
